// File: rtl/rv_exception_unit.sv
// rtl/rv_exception_unit.sv - machine-mode trap CSRs, interrupt synchroniser and interrupt request
// Optional feature macro: URV_TIMER_IRQ_EN (timer interrupt path, MTIP/MTIE); disabled when undefined.

`ifndef CSR_ID_MSTATUS
`define CSR_ID_MSTATUS 12'h300
`endif
`ifndef CSR_ID_MIE
`define CSR_ID_MIE 12'h304
`endif
`ifndef CSR_ID_MEPC
`define CSR_ID_MEPC 12'h341
`endif
`ifndef CSR_ID_MCAUSE
`define CSR_ID_MCAUSE 12'h342
`endif
`ifndef CSR_ID_MIP
`define CSR_ID_MIP 12'h344
`endif

module rv_exception_unit #(
  parameter logic [31:0] g_TRAP_VECTOR     = 32'h00000008,
  parameter int          g_IRQ_SYNC_STAGES = 2   // legal range 2..3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        x_stall_i,
  input  logic        x_kill_i,
  input  logic        d_is_csr_i,
  input  logic        d_is_eret_i,
  input  logic [11:0] d_csr_sel_i,
  input  logic [31:0] x_csr_write_value_i,
  input  logic        x_exception_i,
  input  logic [3:0]  x_exception_cause_i,
  input  logic [31:0] x_pc_i,
  input  logic        x_irq_taken_i,
  input  logic        irq_i,
  input  logic        timer_irq_i,
  output logic        x_irq_o,
  output logic [31:0] x_trap_vector_o,
  output logic [31:0] csr_mstatus_o,
  output logic [31:0] csr_mip_o,
  output logic [31:0] csr_mie_o,
  output logic [31:0] csr_mepc_o,
  output logic [31:0] csr_mcause_o
);

  logic [g_IRQ_SYNC_STAGES-1:0] irq_sync_q;

  logic        mstatus_mie_q,  mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic        mie_meie_q,     mie_meie_d;
  logic [31:2] mepc_q,         mepc_d;
  logic        mcause_irq_q,   mcause_irq_d;
  logic [3:0]  mcause_code_q,  mcause_code_d;
  logic        irq_q,          irq_d;

  logic meip;
  logic mtip;
  logic mtie;
  logic commit;
  logic pending;
  logic trap;
  logic unused_inputs;

  assign meip    = irq_sync_q[g_IRQ_SYNC_STAGES-1];
  assign commit  = !x_stall_i && !x_kill_i;
  assign pending = mstatus_mie_q && ((mie_meie_q && meip) || (mtie && mtip));

`ifdef URV_TIMER_IRQ_EN
  logic mtip_q;
  logic mie_mtie_q, mie_mtie_d;

  // Timer level is already synchronous, so one register stage is enough
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtip_q     <= 1'b0;
      mie_mtie_q <= 1'b0;
    end else begin
      mtip_q     <= timer_irq_i;
      mie_mtie_q <= mie_mtie_d;
    end
  end

  assign mtip          = mtip_q;
  assign mtie          = mie_mtie_q;
  assign unused_inputs = ^x_pc_i[1:0];
`else
  assign mtip          = 1'b0;
  assign mtie          = 1'b0;
  assign unused_inputs = ^{x_pc_i[1:0], timer_irq_i};
`endif

  // Synchroniser for the asynchronous external interrupt level
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_sync_q <= '0;
    end else begin
      irq_sync_q <= {irq_sync_q[g_IRQ_SYNC_STAGES-2:0], irq_i};
    end
  end

  // Prioritised trap / return / CSR-write next state; lower-priority events are dropped
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_meie_d     = mie_meie_q;
    mepc_d         = mepc_q;
    mcause_irq_d   = mcause_irq_q;
    mcause_code_d  = mcause_code_q;
`ifdef URV_TIMER_IRQ_EN
    mie_mtie_d     = mie_mtie_q;
`endif
    trap           = 1'b0;

    if (x_exception_i && commit) begin
      trap           = 1'b1;
      mepc_d         = x_pc_i[31:2];
      mcause_irq_d   = 1'b0;
      mcause_code_d  = x_exception_cause_i;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (x_irq_taken_i && irq_q) begin
      trap           = 1'b1;
      mepc_d         = x_pc_i[31:2];
      mcause_irq_d   = 1'b1;
`ifdef URV_TIMER_IRQ_EN
      // External outranks timer when both are pending and enabled
      mcause_code_d  = (meip && mie_meie_q) ? 4'hB : 4'h7;
`else
      mcause_code_d  = 4'hB;
`endif
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (d_is_eret_i && commit) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (d_is_csr_i && commit) begin
      case (d_csr_sel_i)
        `CSR_ID_MSTATUS: begin
          mstatus_mie_d  = x_csr_write_value_i[3];
          mstatus_mpie_d = x_csr_write_value_i[7];
        end
        `CSR_ID_MIE: begin
          mie_meie_d = x_csr_write_value_i[11];
`ifdef URV_TIMER_IRQ_EN
          mie_mtie_d = x_csr_write_value_i[7];
`endif
        end
        `CSR_ID_MEPC: begin
          mepc_d = x_csr_write_value_i[31:2];
        end
        `CSR_ID_MCAUSE: begin
          mcause_irq_d  = x_csr_write_value_i[31];
          mcause_code_d = x_csr_write_value_i[3:0];
        end
        default: ;  // mip is read-only; unknown addresses are ignored
      endcase
    end

    // A trap this cycle clears MIE, so the request must not linger past it
    irq_d = pending && !trap;
  end

  // Trap state and interrupt request registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_meie_q     <= 1'b0;
      mepc_q         <= '0;
      mcause_irq_q   <= 1'b0;
      mcause_code_q  <= '0;
      irq_q          <= 1'b0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_meie_q     <= mie_meie_d;
      mepc_q         <= mepc_d;
      mcause_irq_q   <= mcause_irq_d;
      mcause_code_q  <= mcause_code_d;
      irq_q          <= irq_d;
    end
  end

  assign x_irq_o         = irq_q;
  assign x_trap_vector_o = g_TRAP_VECTOR;
  assign csr_mstatus_o   = {24'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
  assign csr_mie_o       = {20'b0, mie_meie_q, 3'b0, mtie, 7'b0};
  assign csr_mip_o       = {20'b0, meip, 3'b0, mtip, 7'b0};
  assign csr_mepc_o      = {mepc_q, 2'b00};
  assign csr_mcause_o    = {mcause_irq_q, 27'b0, mcause_code_q};

endmodule

// File: tb/tb_rv_exception_unit.sv
// tb/tb_rv_exception_unit.sv - self-checking bench for rv_exception_unit with reference model

module tb_rv_exception_unit;

  localparam int STAGES = 2;
`ifdef URV_TIMER_IRQ_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        x_stall_i, x_kill_i, d_is_csr_i, d_is_eret_i;
  logic [11:0] d_csr_sel_i;
  logic [31:0] x_csr_write_value_i;
  logic        x_exception_i;
  logic [3:0]  x_exception_cause_i;
  logic [31:0] x_pc_i;
  logic        x_irq_taken_i, irq_i, timer_irq_i;
  logic        x_irq_o;
  logic [31:0] x_trap_vector_o, csr_mstatus_o, csr_mip_o, csr_mie_o, csr_mepc_o, csr_mcause_o;

  int n_vec = 0;
  int n_bad = 0;

  // reference model state (architectural view)
  logic [31:0] m_mstatus, m_mie, m_mepc, m_mcause;
  logic        m_irq;
  logic [3:0]  irq_hist;   // irq_hist[k] = irq_i seen k+1 clock edges ago
  logic        timer_q;

  logic [11:0] sels [6] = '{12'h300, 12'h304, 12'h341, 12'h342, 12'h344, 12'h7C0};

  rv_exception_unit #(.g_TRAP_VECTOR(32'h00000008), .g_IRQ_SYNC_STAGES(STAGES)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .x_stall_i(x_stall_i), .x_kill_i(x_kill_i),
    .d_is_csr_i(d_is_csr_i), .d_is_eret_i(d_is_eret_i), .d_csr_sel_i(d_csr_sel_i),
    .x_csr_write_value_i(x_csr_write_value_i), .x_exception_i(x_exception_i),
    .x_exception_cause_i(x_exception_cause_i), .x_pc_i(x_pc_i), .x_irq_taken_i(x_irq_taken_i),
    .irq_i(irq_i), .timer_irq_i(timer_irq_i), .x_irq_o(x_irq_o), .x_trap_vector_o(x_trap_vector_o),
    .csr_mstatus_o(csr_mstatus_o), .csr_mip_o(csr_mip_o), .csr_mie_o(csr_mie_o),
    .csr_mepc_o(csr_mepc_o), .csr_mcause_o(csr_mcause_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_mip();
    model_mip = (irq_hist[STAGES-1] ? 32'h800 : 32'h0) | ((TIMER_EN && timer_q) ? 32'h80 : 32'h0);
  endfunction

  task automatic model_reset();
    m_mstatus = 0; m_mie = 0; m_mepc = 0; m_mcause = 0; m_irq = 0; irq_hist = 0; timer_q = 0;
  endtask

  // one clock edge of architectural behaviour, evaluated from the current inputs
  task automatic model_step();
    logic [31:0] mip;
    bit commit, pend, trap;
    commit = !x_stall_i && !x_kill_i;
    mip    = model_mip();
    pend   = m_mstatus[3] && ((m_mie & mip) != 0);
    trap   = 0;
    if (x_exception_i && commit) begin
      m_mepc = x_pc_i & 32'hFFFFFFFC;
      m_mcause = {28'b0, x_exception_cause_i};
      m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
      trap = 1;
    end else if (x_irq_taken_i && m_irq) begin
      m_mepc = x_pc_i & 32'hFFFFFFFC;
      m_mcause = ((mip & m_mie & 32'h800) != 0 || !TIMER_EN) ? 32'h8000000B : 32'h80000007;
      m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
      trap = 1;
    end else if (d_is_eret_i && commit) begin
      m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
    end else if (d_is_csr_i && commit) begin
      case (d_csr_sel_i)
        12'h300: m_mstatus = x_csr_write_value_i & 32'h88;
        12'h304: m_mie     = x_csr_write_value_i & (TIMER_EN ? 32'h880 : 32'h800);
        12'h341: m_mepc    = x_csr_write_value_i & 32'hFFFFFFFC;
        12'h342: m_mcause  = x_csr_write_value_i & 32'h8000000F;
        default: ;
      endcase
    end
    m_irq    = pend && !trap;
    irq_hist = {irq_hist[2:0], irq_i};
    timer_q  = timer_irq_i;
  endtask

  task automatic check_all();
    chk("x_irq_o", 32'(x_irq_o), 32'(m_irq));
    chk("trap_vector", x_trap_vector_o, 32'h00000008);
    chk("mstatus", csr_mstatus_o, m_mstatus);
    chk("mie", csr_mie_o, m_mie);
    chk("mip", csr_mip_o, model_mip());
    chk("mepc", csr_mepc_o, m_mepc);
    chk("mcause", csr_mcause_o, m_mcause);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_i);
    #1;
    check_all();
  endtask

  task automatic idle();
    x_stall_i = 0; x_kill_i = 0; d_is_csr_i = 0; d_is_eret_i = 0; d_csr_sel_i = 0;
    x_csr_write_value_i = 0; x_exception_i = 0; x_exception_cause_i = 0; x_pc_i = 0;
    x_irq_taken_i = 0;
  endtask

  task automatic csr_wr(input logic [11:0] sel, input logic [31:0] val, input logic kill);
    d_is_csr_i = 1; d_csr_sel_i = sel; x_csr_write_value_i = val; x_kill_i = kill;
    tick();
    idle();
  endtask

  initial begin
    idle();
    irq_i = 0; timer_irq_i = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_all();
    rst_i = 0;

    // mstatus write: killed write dropped, committed write masked
    csr_wr(12'h300, 32'hFFFFFFFF, 1'b1);
    chk("mstatus_killed", csr_mstatus_o, 32'h0);
    csr_wr(12'h300, 32'hFFFFFFFF, 1'b0);
    chk("mstatus_masked", csr_mstatus_o, 32'h88);

    // external interrupt latency
    csr_wr(12'h304, 32'h800, 1'b0);
    irq_i = 1;
    tick(); chk("irq_lat1", 32'(x_irq_o), 32'h0);
    tick(); chk("irq_lat2", 32'(x_irq_o), 32'h0);
    tick(); chk("irq_lat3", 32'(x_irq_o), 32'h1);

    // take the interrupt
    x_irq_taken_i = 1; x_pc_i = 32'h1003;
    tick(); idle();
    chk("take_mepc", csr_mepc_o, 32'h1000);
    chk("take_mcause", csr_mcause_o, 32'h8000000B);
    chk("take_mstatus", csr_mstatus_o, 32'h80);
    chk("take_irq_drop", 32'(x_irq_o), 32'h0);

    // trap return re-enables and the still-high irq reasserts
    d_is_eret_i = 1;
    tick(); idle();
    chk("eret_mstatus", csr_mstatus_o, 32'h88);
    tick();
    chk("eret_reassert", 32'(x_irq_o), 32'h1);

    // exception outranks a simultaneous CSR write
    x_exception_i = 1; x_exception_cause_i = 4'd2; x_pc_i = 32'h200;
    d_is_csr_i = 1; d_csr_sel_i = 12'h341; x_csr_write_value_i = 32'h55;
    tick(); idle();
    chk("exc_mepc", csr_mepc_o, 32'h200);
    chk("exc_mcause", csr_mcause_o, 32'h2);
    chk("exc_mie_bit", 32'(csr_mstatus_o[3]), 32'h0);
    irq_i = 0;

    // timer path (present or absent depending on build)
    csr_wr(12'h304, 32'h880, 1'b0);
    chk("mie_timer_mask", csr_mie_o, TIMER_EN ? 32'h880 : 32'h800);
    csr_wr(12'h300, 32'h8, 1'b0);
    tick(); tick();
    chk("irq_quiet", 32'(x_irq_o), 32'h0);
    timer_irq_i = 1;
    tick(); tick();
    chk("timer_lat2", 32'(x_irq_o), 32'(TIMER_EN));
    tick(); tick(); tick();
    chk("timer_hold", 32'(x_irq_o), 32'(TIMER_EN));
    x_irq_taken_i = 1; x_pc_i = 32'h44;
    tick(); idle();
    chk("timer_mcause", csr_mcause_o, TIMER_EN ? 32'h80000007 : 32'h2);

    // both sources pending: external wins
    csr_wr(12'h300, 32'h8, 1'b0);
    irq_i = 1;
    tick(); tick(); tick(); tick();
    chk("both_irq", 32'(x_irq_o), 32'h1);
    x_irq_taken_i = 1; x_pc_i = 32'h88;
    tick(); idle();
    chk("both_mcause", csr_mcause_o, 32'h8000000B);
    chk("both_mepc", csr_mepc_o, 32'h88);

    // take while no request is a no-op
    x_irq_taken_i = 1; x_pc_i = 32'h300;
    tick(); idle();
    chk("take_noreq_mepc", csr_mepc_o, 32'h88);

    // asynchronous reset mid-cycle
    #3;
    rst_i = 1;
    model_reset();
    #1;
    check_all();
    chk("rst_mepc", csr_mepc_o, 32'h0);
    @(posedge clk_i); @(posedge clk_i);
    #1;
    check_all();
    rst_i = 0;

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      x_stall_i           = ($urandom_range(0, 3) == 0);
      x_kill_i            = ($urandom_range(0, 5) == 0);
      d_is_csr_i          = ($urandom_range(0, 1) == 1);
      d_csr_sel_i         = sels[$urandom_range(0, 5)];
      x_csr_write_value_i = $urandom;
      x_exception_i       = ($urandom_range(0, 9) == 0);
      x_exception_cause_i = 4'($urandom);
      x_pc_i              = $urandom;
      x_irq_taken_i       = ($urandom_range(0, 2) == 0);
      d_is_eret_i         = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 7) == 0) irq_i = ~irq_i;
      if ($urandom_range(0, 7) == 0) timer_irq_i = ~timer_irq_i;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
